// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller for an external simple-dual-port BRAM, with a 3-word prefetch buffer on the read side.
// Latency: a write into an empty FIFO appears on DO_VALID 2+L cycles later (L = 1 + DO_REG); all status outputs are registered.
// Backpressure: a write while FULL is dropped and flagged on WRERR; RD_READY=0 holds DO and stops prefetch once the buffer is committed.
// Optional feature: define BRAM_FIFO_CTRL_COUNT_EN to build the COUNT occupancy counter (otherwise COUNT reads 0).
module bram_fifo_ctrl #(
    parameter int DATA_WIDTH          = 36,
    parameter     BRAM_SIZE           = "36Kb",
    parameter int DO_REG              = 0,
    parameter int ALMOST_FULL_OFFSET  = 16,
    parameter int ALMOST_EMPTY_OFFSET = 16,
    localparam int SIZE_N = (BRAM_SIZE == "36Kb") ? 2 : 1,
    localparam int DEPTH  = (DATA_WIDTH > 36) ? 512 :
                            (DATA_WIDTH > 18) ? 512 * SIZE_N :
                            (DATA_WIDTH > 9)  ? 1024 * SIZE_N :
                            (DATA_WIDTH > 4)  ? 2048 * SIZE_N :
                            (DATA_WIDTH > 2)  ? 4096 * SIZE_N :
                            (DATA_WIDTH == 2) ? 8192 * SIZE_N : 16384 * SIZE_N,
    localparam int AW     = $clog2(DEPTH),
    localparam int WE_W   = (DATA_WIDTH > 36) ? 8 : (DATA_WIDTH > 18) ? 4 : (DATA_WIDTH > 9) ? 2 : 1,
    localparam int CW     = $clog2(DEPTH + 4)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WREN,
    input  logic [DATA_WIDTH-1:0] DI,
    output logic                  FULL,
    output logic                  ALMOSTFULL,
    output logic                  WRERR,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DO_VALID,
    input  logic                  RD_READY,
    output logic                  EMPTY,
    output logic                  ALMOSTEMPTY,
    output logic [CW-1:0]         COUNT,
    output logic [WE_W-1:0]       BRAM_WE,
    output logic [AW-1:0]         BRAM_WRADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    output logic                  BRAM_RDEN,
    output logic [AW-1:0]         BRAM_RDADDR,
    output logic                  BRAM_REGCE,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);
    localparam int              L       = 1 + DO_REG;
    localparam logic [AW:0]     DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     AF_TH   = (AW + 1)'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CW-1:0]   AE_TH   = CW'(ALMOST_EMPTY_OFFSET);

    generate
        if (!((BRAM_SIZE == "18Kb" || BRAM_SIZE == "36Kb") &&
              DATA_WIDTH >= 1 && DATA_WIDTH <= 72 &&
              !(DATA_WIDTH > 36 && BRAM_SIZE != "36Kb") &&
              (DO_REG == 0 || DO_REG == 1))) begin : g_bad_cfg
            $error("bram_fifo_ctrl: illegal DATA_WIDTH/BRAM_SIZE/DO_REG combination");
        end
    endgenerate

    // Number of reads currently travelling through the BRAM pipeline.
    function automatic logic [2:0] ones(input logic [L-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < L; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    // Pointers carry one extra wrap bit so occupancy can reach DEPTH.
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           bram_occ, bram_occ_d;
    logic                  full_q, full_d, afull_q, afull_d, wrerr_q, wrerr_d;
    logic                  empty_q, empty_d, aempty_q, aempty_d;
    logic [L-1:0]          infl_q, infl_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    logic [1:0]            bcnt_q, bcnt_d, widx;
    logic [2:0]            credit_used;
    logic                  push, pop, issue, capture;
    logic [CW-1:0]         total_d;

    // Push/pop/prefetch decisions and next state of pointers, pipeline and prefetch buffer.
    always_comb begin
        push     = WREN && !full_q && !RST;
        pop      = (bcnt_q != 2'd0) && RD_READY;
        bram_occ = wr_ptr_q - rd_ptr_q;
        // Credits count the buffer as it will be after this cycle's pop, so L=2 still sustains one word per cycle.
        credit_used = {1'b0, bcnt_q} + ones(infl_q) - {2'b00, pop};
        issue    = !RST && (bram_occ != '0) && (credit_used < 3'd3);
        capture  = infl_q[L-1];

        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, issue};
        bram_occ_d = wr_ptr_d - rd_ptr_d;

        infl_d    = '0;
        infl_d[0] = issue;
        for (int i = 1; i < L; i++) infl_d[i] = infl_q[i-1];

        for (int i = 0; i < 3; i++) buf_d[i] = buf_q[i];
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        widx = bcnt_q - {1'b0, pop};
        for (int i = 0; i < 3; i++) begin
            if (capture && widx == 2'(i)) buf_d[i] = BRAM_DO;
        end
        bcnt_d = bcnt_q - {1'b0, pop} + {1'b0, capture};

        full_d  = (bram_occ_d == DEPTH_V);
        afull_d = (bram_occ_d >= AF_TH);
        wrerr_d = WREN && full_q;
    end

`ifdef BRAM_FIFO_CTRL_COUNT_EN
    logic [CW-1:0] count_q, count_d;

    // Running total of stored words: every accepted write adds one, every pop removes one.
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        total_d = count_d;
    end

    // Occupancy counter register.
    always_ff @(posedge CLK) begin
        if (RST) count_q <= '0;
        else     count_q <= count_d;
    end

    assign COUNT = count_q;
`else
    // Without the counter, occupancy is rebuilt from the BRAM, pipeline and buffer fill levels.
    always_comb begin
        total_d = CW'(bram_occ_d) + CW'(ones(infl_d)) + CW'(bcnt_d);
    end

    assign COUNT = '0;
`endif

    // Read-side status flags derived from next-cycle occupancy.
    always_comb begin
        empty_d  = (total_d == '0);
        aempty_d = (total_d <= AE_TH);
    end

    // State registers; reset discards anything still in the BRAM pipeline.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            infl_q   <= '0;
            bcnt_q   <= '0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wrerr_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            infl_q   <= infl_d;
            bcnt_q   <= bcnt_d;
            for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
            full_q   <= full_d;
            afull_q  <= afull_d;
            wrerr_q  <= wrerr_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
        end
    end

    assign FULL        = full_q;
    assign ALMOSTFULL  = afull_q;
    assign WRERR       = wrerr_q;
    assign EMPTY       = empty_q;
    assign ALMOSTEMPTY = aempty_q;
    assign DO          = buf_q[0];
    assign DO_VALID    = (bcnt_q != 2'd0);
    assign BRAM_WE     = {WE_W{push}};
    assign BRAM_WRADDR = wr_ptr_q[AW-1:0];
    assign BRAM_DI     = DI;
    assign BRAM_RDEN   = issue;
    assign BRAM_RDADDR = rd_ptr_q[AW-1:0];
    assign BRAM_REGCE  = (DO_REG != 0);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: a 36b/DO_REG=0 instance and a 72b/DO_REG=1 instance, each with a behavioural BRAM.
// Expected data comes from queue scoreboards; flags and COUNT from the number of words written minus words popped.
// Every comparison steps vectors; every miss steps miscompares and prints a FAIL line.
module tb_bram_fifo_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int count_en;

    // Instance A: 36 bits, 36Kb, DEPTH 1024, DO_REG 0
    logic        a_rst, a_wren, a_rd_ready;
    logic [35:0] a_di, a_do, a_bram_di, a_bram_do;
    logic        a_full, a_af, a_wrerr, a_do_valid, a_empty, a_ae, a_rden, a_regce;
    logic [10:0] a_count;
    logic [3:0]  a_we;
    logic [9:0]  a_wraddr, a_rdaddr;
    logic [35:0] mem_a [1024];

    // Instance B: 72 bits, 36Kb, DEPTH 512, DO_REG 1
    logic        b_rst, b_wren, b_rd_ready;
    logic [71:0] b_di, b_do, b_bram_di, b_bram_do, b_lat;
    logic        b_full, b_af, b_wrerr, b_do_valid, b_empty, b_ae, b_rden, b_regce;
    logic [9:0]  b_count;
    logic [7:0]  b_we;
    logic [8:0]  b_wraddr, b_rdaddr;
    logic [71:0] mem_b [512];

    bram_fifo_ctrl #(.DATA_WIDTH(36), .BRAM_SIZE("36Kb"), .DO_REG(0),
                     .ALMOST_FULL_OFFSET(16), .ALMOST_EMPTY_OFFSET(16)) dut_a (
        .CLK(clk), .RST(a_rst), .WREN(a_wren), .DI(a_di), .FULL(a_full), .ALMOSTFULL(a_af),
        .WRERR(a_wrerr), .DO(a_do), .DO_VALID(a_do_valid), .RD_READY(a_rd_ready),
        .EMPTY(a_empty), .ALMOSTEMPTY(a_ae), .COUNT(a_count), .BRAM_WE(a_we),
        .BRAM_WRADDR(a_wraddr), .BRAM_DI(a_bram_di), .BRAM_RDEN(a_rden),
        .BRAM_RDADDR(a_rdaddr), .BRAM_REGCE(a_regce), .BRAM_DO(a_bram_do));

    bram_fifo_ctrl #(.DATA_WIDTH(72), .BRAM_SIZE("36Kb"), .DO_REG(1),
                     .ALMOST_FULL_OFFSET(16), .ALMOST_EMPTY_OFFSET(16)) dut_b (
        .CLK(clk), .RST(b_rst), .WREN(b_wren), .DI(b_di), .FULL(b_full), .ALMOSTFULL(b_af),
        .WRERR(b_wrerr), .DO(b_do), .DO_VALID(b_do_valid), .RD_READY(b_rd_ready),
        .EMPTY(b_empty), .ALMOSTEMPTY(b_ae), .COUNT(b_count), .BRAM_WE(b_we),
        .BRAM_WRADDR(b_wraddr), .BRAM_DI(b_bram_di), .BRAM_RDEN(b_rden),
        .BRAM_RDADDR(b_rdaddr), .BRAM_REGCE(b_regce), .BRAM_DO(b_bram_do));

    // Behavioural SDP BRAMs: synchronous read, B adds the optional output register.
    always @(posedge clk) begin
        if (a_we != '0) mem_a[a_wraddr] <= a_bram_di;
        if (a_rden) a_bram_do <= mem_a[a_rdaddr];
        if (b_we != '0) mem_b[b_wraddr] <= b_bram_di;
        if (b_rden) b_lat <= mem_b[b_rdaddr];
        if (b_regce) b_bram_do <= b_lat;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1; a_wren = 1'b0; a_rd_ready = 1'b0;
        tick();
        a_rst = 1'b0;
    endtask

    task automatic reset_b();
        b_rst = 1'b1; b_wren = 1'b0; b_rd_ready = 1'b0;
        tick();
        b_rst = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; a_wren = 1'b1; b_wren = 1'b1;
        a_di = 36'h123456789; b_di = '1; a_rd_ready = 1'b1; b_rd_ready = 1'b1;
        #1;
        vectors++;
        if (a_we !== 4'h0) begin miscompares++; $display("FAIL rst_a_we: got %h expected 0", a_we); end
        vectors++;
        if (b_we !== 8'h00) begin miscompares++; $display("FAIL rst_b_we: got %h expected 0", b_we); end
        tick();
        vectors++;
        if ({a_full, a_af, a_wrerr, a_empty, a_ae, a_do_valid} !== 6'b000110) begin
            miscompares++;
            $display("FAIL rst_a_flags: got %b expected 000110", {a_full, a_af, a_wrerr, a_empty, a_ae, a_do_valid});
        end
        vectors++;
        if ({b_full, b_af, b_wrerr, b_empty, b_ae, b_do_valid} !== 6'b000110) begin
            miscompares++;
            $display("FAIL rst_b_flags: got %b expected 000110", {b_full, b_af, b_wrerr, b_empty, b_ae, b_do_valid});
        end
        vectors++;
        if (a_do !== 36'h0 || a_count !== 11'h0) begin
            miscompares++; $display("FAIL rst_a_do_count: got %h/%0d expected 0/0", a_do, a_count);
        end
        vectors++;
        if (b_do !== 72'h0 || b_count !== 10'h0) begin
            miscompares++; $display("FAIL rst_b_do_count: got %h/%0d expected 0/0", b_do, b_count);
        end
        vectors++;
        if (a_we !== 4'h0 || a_rden !== 1'b0) begin
            miscompares++; $display("FAIL rst_a_held: got we=%h rden=%b expected 0/0", a_we, a_rden);
        end
        vectors++;
        if (a_regce !== 1'b0 || b_regce !== 1'b1) begin
            miscompares++; $display("FAIL regce: got a=%b b=%b expected 0/1", a_regce, b_regce);
        end
        a_rst = 1'b0; b_rst = 1'b0; a_wren = 1'b0; b_wren = 1'b0;
        a_rd_ready = 1'b0; b_rd_ready = 1'b0;
        tick();
    endtask

    // One write into an empty FIFO with DO_REG=0: visible in cycle 3, FIFO empty after the pop.
    task automatic test_first_word();
        reset_a();
        a_wren = 1'b1; a_di = 36'h0ABCDE; a_rd_ready = 1'b1;
        tick();
        a_wren = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (a_do_valid !== (c == 3)) begin
                miscompares++; $display("FAIL first_valid_c%0d: got %b expected %b", c, a_do_valid, (c == 3));
            end
            if (c == 3) begin
                vectors++;
                if (a_do !== 36'h0ABCDE) begin miscompares++; $display("FAIL first_do: got %h expected 0abcde", a_do); end
            end
            if (c == 1 || c == 4) begin
                vectors++;
                if (a_empty !== (c == 4)) begin
                    miscompares++; $display("FAIL first_empty_c%0d: got %b expected %b", c, a_empty, (c == 4));
                end
            end
            tick();
        end
    endtask

    // Fill to capacity DEPTH+3 with reads stalled, then overflow once and drain.
    task automatic test_full_wrerr();
        logic [35:0] q[$];
        logic [63:0] r;
        int          n;
        reset_a();
        a_rd_ready = 1'b0;
        for (int k = 1; k <= 1028; k++) begin
            r = {$urandom(), $urandom()};
            a_wren = 1'b1; a_di = r[35:0];
            if (k <= 1027) q.push_back(r[35:0]);
            tick();
            vectors++;
            if (a_full !== (k >= 1027)) begin
                miscompares++; $display("FAIL full_k%0d: got %b expected %b", k, a_full, (k >= 1027));
            end
            vectors++;
            if (a_af !== (k >= 1011)) begin
                miscompares++; $display("FAIL afull_k%0d: got %b expected %b", k, a_af, (k >= 1011));
            end
            vectors++;
            if (a_wrerr !== (k == 1028)) begin
                miscompares++; $display("FAIL wrerr_k%0d: got %b expected %b", k, a_wrerr, (k == 1028));
            end
        end
        a_wren = 1'b0;
        tick();
        vectors++;
        if (a_wrerr !== 1'b0 || a_full !== 1'b1) begin
            miscompares++; $display("FAIL wrerr_pulse: got wrerr=%b full=%b expected 0/1", a_wrerr, a_full);
        end
        a_rd_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 1300 && n < 1027; cyc++) begin
            if (a_do_valid) begin
                vectors++;
                if (a_do !== q[0]) begin miscompares++; $display("FAIL drain_w%0d: got %h expected %h", n, a_do, q[0]); end
                void'(q.pop_front());
                n++;
            end
            tick();
        end
        vectors++;
        if (n != 1027) begin miscompares++; $display("FAIL drain_count: got %0d expected 1027", n); end
        tick();
        vectors++;
        if (a_empty !== 1'b1 || a_do_valid !== 1'b0 || a_count !== 11'h0) begin
            miscompares++; $display("FAIL drain_end: got empty=%b valid=%b count=%0d expected 1/0/0", a_empty, a_do_valid, a_count);
        end
    endtask

    // DO_REG=1 with RD_READY toggling: first word in cycle 4, held while stalled, nothing lost.
    task automatic test_do_reg_stall();
        logic [71:0] q[$];
        logic [95:0] r;
        int          n;
        logic        prev_stall;
        reset_b();
        n = 0; prev_stall = 1'b0;
        for (int c = 0; c < 60; c++) begin
            r = {$urandom(), $urandom(), $urandom()};
            b_wren = (c < 8); b_di = r[71:0];
            if (c < 8) q.push_back(r[71:0]);
            b_rd_ready = (c % 2 == 0);
            if (c >= 1 && c <= 4) begin
                vectors++;
                if (b_do_valid !== (c == 4)) begin
                    miscompares++; $display("FAIL doreg_latency_c%0d: got %b expected %b", c, b_do_valid, (c == 4));
                end
            end
            if (prev_stall) begin
                vectors++;
                if (b_do_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid_c%0d: got 0 expected 1", c); end
            end
            if (b_do_valid) begin
                vectors++;
                if (q.size() == 0 || b_do !== q[0]) begin
                    miscompares++; $display("FAIL stall_data_c%0d: got %h expected word %0d", c, b_do, n);
                end else if (b_rd_ready) begin
                    void'(q.pop_front());
                    n++;
                end
            end
            prev_stall = b_do_valid && !b_rd_ready;
            tick();
        end
        b_wren = 1'b0;
        vectors++;
        if (n != 8) begin miscompares++; $display("FAIL stall_count: got %0d expected 8", n); end
    endtask

    // 2000 random words through the 512-deep instance: order, flags, count and address wrap.
    task automatic test_random_wrap();
        logic [71:0] q[$];
        logic [95:0] r;
        int          pushed, wr_idx, rd_idx, cnt, cyc;
        reset_b();
        pushed = 0; wr_idx = 0; rd_idx = 0; cnt = 0; cyc = 0;
        while ((pushed < 2000 || q.size() != 0) && cyc < 12000) begin
            r = {$urandom(), $urandom(), $urandom()};
            b_wren = (pushed < 2000) && ($urandom_range(0, 1) == 1);
            b_di = r[71:0];
            b_rd_ready = ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (b_empty !== (cnt == 0) || b_ae !== (cnt <= 16)) begin
                miscompares++; $display("FAIL rnd_flags_c%0d: got empty=%b ae=%b for %0d words", cyc, b_empty, b_ae, cnt);
            end
            vectors++;
            if (b_count !== 10'(count_en * cnt)) begin
                miscompares++; $display("FAIL rnd_count_c%0d: got %0d expected %0d", cyc, b_count, count_en * cnt);
            end
            if (cnt < 512) begin
                vectors++;
                if (b_full !== 1'b0) begin miscompares++; $display("FAIL rnd_full_c%0d: got 1 expected 0 at %0d words", cyc, cnt); end
            end
            if (b_rden) begin
                vectors++;
                if (b_rdaddr !== 9'(rd_idx % 512) || rd_idx >= wr_idx) begin
                    miscompares++; $display("FAIL rnd_rdaddr_r%0d: got %0d expected %0d", rd_idx, b_rdaddr, rd_idx % 512);
                end
                rd_idx++;
            end
            vectors++;
            if (b_we !== (b_wren ? 8'hFF : 8'h00)) begin
                miscompares++; $display("FAIL rnd_we_c%0d: got %h expected %h", cyc, b_we, (b_wren ? 8'hFF : 8'h00));
            end
            if (b_wren) begin
                vectors++;
                if (b_wraddr !== 9'(wr_idx % 512) || b_bram_di !== b_di) begin
                    miscompares++; $display("FAIL rnd_wraddr_w%0d: got %0d expected %0d", wr_idx, b_wraddr, wr_idx % 512);
                end
                wr_idx++;
                q.push_back(r[71:0]);
                pushed++;
                cnt++;
            end
            if (b_do_valid && b_rd_ready) begin
                vectors++;
                if (q.size() == 0 || b_do !== q[0]) begin
                    miscompares++; $display("FAIL rnd_data_c%0d: got %h expected %h", cyc, b_do, (q.size() != 0) ? q[0] : 72'h0);
                end
                if (q.size() != 0) void'(q.pop_front());
                cnt--;
            end
            tick();
            cyc++;
        end
        b_wren = 1'b0; b_rd_ready = 1'b0;
        vectors++;
        if (pushed != 2000 || q.size() != 0 || rd_idx != 2000) begin
            miscompares++; $display("FAIL rnd_done: pushed %0d left %0d reads %0d expected 2000/0/2000", pushed, q.size(), rd_idx);
        end
    endtask

    // Reset while 3 words are stored and 2 reads are in flight; the next word must come out alone.
    task automatic test_reset_midflight();
        int n;
        reset_b();
        for (int c = 0; c < 3; c++) begin
            b_wren = 1'b1; b_di = 72'(100 + c);
            tick();
        end
        b_rst = 1'b1; b_wren = 1'b1; b_di = 72'hBAD;
        #1;
        vectors++;
        if (b_we !== 8'h00 || b_rden !== 1'b0) begin
            miscompares++; $display("FAIL midrst_bram: got we=%h rden=%b expected 0/0", b_we, b_rden);
        end
        tick();
        b_rst = 1'b0; b_wren = 1'b0;
        vectors++;
        if (b_do_valid !== 1'b0 || b_empty !== 1'b1 || b_count !== 10'h0) begin
            miscompares++; $display("FAIL midrst_state: got valid=%b empty=%b count=%0d expected 0/1/0", b_do_valid, b_empty, b_count);
        end
        b_wren = 1'b1; b_di = 72'h55; b_rd_ready = 1'b1;
        tick();
        b_wren = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (b_do_valid) begin
                vectors++;
                if (b_do !== 72'h55) begin miscompares++; $display("FAIL midrst_data: got %h expected 55", b_do); end
                n++;
            end
            tick();
        end
        vectors++;
        if (n != 1 || b_empty !== 1'b1) begin
            miscompares++; $display("FAIL midrst_count: got %0d words empty=%b expected 1/1", n, b_empty);
        end
        b_rd_ready = 1'b0;
    endtask

    // 10 writes then 4 pops leaves 6 words: COUNT (when built) and ALMOSTEMPTY reflect that.
    task automatic test_count();
        logic [35:0] q[$];
        reset_a();
        for (int c = 0; c < 10; c++) begin
            a_wren = 1'b1; a_di = 36'($urandom()); q.push_back(a_di);
            tick();
        end
        a_wren = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        a_rd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (a_do_valid !== 1'b1 || a_do !== q[0]) begin
                miscompares++; $display("FAIL count_pop%0d: got valid=%b do=%h expected 1/%h", c, a_do_valid, a_do, q[0]);
            end
            void'(q.pop_front());
            tick();
        end
        a_rd_ready = 1'b0;
        tick();
        vectors++;
        if (a_count !== 11'(6 * count_en)) begin
            miscompares++; $display("FAIL count_value: got %0d expected %0d", a_count, 6 * count_en);
        end
        vectors++;
        if (a_ae !== 1'b1 || a_empty !== 1'b0 || a_do_valid !== 1'b1) begin
            miscompares++; $display("FAIL count_flags: got ae=%b empty=%b valid=%b expected 1/0/1", a_ae, a_empty, a_do_valid);
        end
    endtask

    initial begin
`ifdef BRAM_FIFO_CTRL_COUNT_EN
        count_en = 1;
`else
        count_en = 0;
`endif
        a_rst = 1'b1; b_rst = 1'b1; a_wren = 1'b0; b_wren = 1'b0;
        a_di = '0; b_di = '0; a_rd_ready = 1'b0; b_rd_ready = 1'b0;
        tick();
        tick();
        test_reset();
        test_first_word();
        test_full_wrerr();
        test_do_reg_stall();
        test_random_wrap();
        test_reset_midflight();
        test_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
